// File: rtl/addf_pipe.sv
// rtl/addf_pipe.sv - pipelined WIDTH-bit add/subtract unit, one SEG-bit carry segment per stage
// Operands skew forward, sum bits deskew, so S/CO/OV emerge aligned NSEG edges after accept.
module addf_pipe #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV
);

  localparam int NSEG = (WIDTH + SEG - 1) / SEG;
  localparam int LAST = NSEG - 1;

  logic             en;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  logic [NSEG-1:0]  v_q;
  logic [NSEG-1:0]  c_q;
  logic [NSEG-1:0]  c_nxt;
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] s_q   [NSEG];
  logic [WIDTH-1:0] s_nxt [NSEG];

  assign en       = !OUT_VALID || OUT_READY;
  assign IN_READY = en;

  // Operands are zeroed on empty slots so undriven inputs never enter the pipe.
  assign a_in = IN_VALID ? A : '0;
  assign b_in = IN_VALID ? (SUB ? ~B : B) : '0;
  assign c_in = IN_VALID & (SUB | CI);

  always_comb begin : seg_add
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic             cy;
    int               prev;
    sa    = '0;
    sb    = '0;
    ss    = '0;
    cy    = 1'b0;
    prev  = 0;
    c_nxt = '0;
    for (int k = 0; k < NSEG; k++) begin
      prev = (k == 0) ? 0 : k - 1;
      sa   = (k == 0) ? a_in : a_q[prev];
      sb   = (k == 0) ? b_in : b_q[prev];
      ss   = (k == 0) ? '0 : s_q[prev];
      cy   = (k == 0) ? c_in : c_q[prev];
      for (int i = 0; i < WIDTH; i++) begin
        if (i / SEG == k) begin
          ss[i] = sa[i] ^ sb[i] ^ cy;
          cy    = (sa[i] & sb[i]) | (cy & (sa[i] ^ sb[i]));
        end
      end
      s_nxt[k] = ss;
      c_nxt[k] = cy;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (en) begin
      v_q[0] <= IN_VALID;
      a_q[0] <= a_in;
      b_q[0] <= b_in;
      for (int k = 1; k < NSEG; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      c_q <= c_nxt;
      for (int k = 0; k < NSEG; k++) begin
        s_q[k] <= s_nxt[k];
      end
    end
  end

  // Carry into the MSB is recovered as s^a^b of that bit, which also covers WIDTH=1.
  assign OUT_VALID = v_q[LAST];
  assign S         = s_q[LAST];
  assign CO        = c_q[LAST];
  assign OV        = s_q[LAST][WIDTH-1] ^ a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ c_q[LAST];

endmodule

// File: tb/tb_addf_pipe.sv
// tb/tb_addf_pipe.sv - self-checking bench for addf_pipe (8/4, 7/3 and 1/1 configurations)
module tb_addf_pipe;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst;
  int   checks;
  int   errors;

  logic       in_valid8, in_ready8, ci8, sub8, out_valid8, out_ready8, co8, ov8;
  logic [7:0] a8, b8, s8;
  logic       in_valid7, in_ready7, ci7, sub7, out_valid7, out_ready7, co7, ov7;
  logic [6:0] a7, b7, s7;
  logic       in_valid1, in_ready1, ci1, sub1, out_valid1, out_ready1, co1, ov1;
  logic [0:0] a1, b1, s1;

  addf_pipe #(.WIDTH(8), .SEG(4)) dut8 (
    .CLK(CLK), .RST(rst), .IN_VALID(in_valid8), .IN_READY(in_ready8), .A(a8), .B(b8),
    .CI(ci8), .SUB(sub8), .OUT_VALID(out_valid8), .OUT_READY(out_ready8), .S(s8), .CO(co8), .OV(ov8)
  );
  addf_pipe #(.WIDTH(7), .SEG(3)) dut7 (
    .CLK(CLK), .RST(rst), .IN_VALID(in_valid7), .IN_READY(in_ready7), .A(a7), .B(b7),
    .CI(ci7), .SUB(sub7), .OUT_VALID(out_valid7), .OUT_READY(out_ready7), .S(s7), .CO(co7), .OV(ov7)
  );
  addf_pipe #(.WIDTH(1), .SEG(1)) dut1 (
    .CLK(CLK), .RST(rst), .IN_VALID(in_valid1), .IN_READY(in_ready1), .A(a1), .B(b1),
    .CI(ci1), .SUB(sub1), .OUT_VALID(out_valid1), .OUT_READY(out_ready1), .S(s1), .CO(co1), .OV(ov1)
  );

  // Reference: whole-word integer arithmetic; result packed as {ov, co, s[31:0]}.
  function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b, logic ci, logic sub);
    longint unsigned mask, av, bv, full;
    logic [31:0] s;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    av   = {32'd0, a} & mask;
    bv   = {32'd0, (sub ? ~b : b)} & mask;
    full = av + bv + 64'(sub | ci);
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    return {ov, co, s};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid8 = 1'b0; in_valid7 = 1'b0; in_valid1 = 1'b0;
    out_ready8 = 1'b1; out_ready7 = 1'b1; out_ready1 = 1'b1;
    a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0;
    a7 = '0; b7 = '0; ci7 = 1'b0; sub7 = 1'b0;
    a1 = '0; b1 = '0; ci1 = 1'b0; sub1 = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if ({out_valid8, s8, co8, ov8} !== 11'd0) begin
      errors++; $display("FAIL reset8 got v=%b s=%h co=%b ov=%b want all 0", out_valid8, s8, co8, ov8);
    end
    checks++;
    if ({out_valid7, s7, co7, ov7} !== 10'd0) begin
      errors++; $display("FAIL reset7 got v=%b s=%h co=%b ov=%b want all 0", out_valid7, s7, co7, ov7);
    end
    checks++;
    if ({out_valid1, s1, co1, ov1} !== 4'd0) begin
      errors++; $display("FAIL reset1 got v=%b s=%h co=%b ov=%b want all 0", out_valid1, s1, co1, ov1);
    end
    rst = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", in_ready8);
    end
  endtask

  task automatic test_directed();
    // {a, b, ci, sub, s, co, ov}
    logic [27:0] tbl [6];
    logic [27:0] t;
    tbl[0] = {8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = {8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = {8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[3] = {8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[4] = {8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = {8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    for (int n = 0; n < 6; n++) begin
      t = tbl[n];
      @(negedge CLK);
      out_ready8 = 1'b1;
      in_valid8 = 1'b1; a8 = t[27:20]; b8 = t[19:12]; ci8 = t[11]; sub8 = t[10];
      #1;
      checks++;
      if (in_ready8 !== 1'b1) begin
        errors++; $display("FAIL dir%0d_ready got %b want 1", n, in_ready8);
      end
      @(posedge CLK); @(negedge CLK);
      in_valid8 = 1'b0; a8 = 'x; b8 = 'x; ci8 = 'x; sub8 = 'x;
      #1;
      checks++;
      if (out_valid8 !== 1'b0) begin
        errors++; $display("FAIL dir%0d_early got valid=%b want 0", n, out_valid8);
      end
      @(posedge CLK); @(negedge CLK); #1;
      checks++;
      if ({out_valid8, s8, co8, ov8} !== {1'b1, t[9:0]}) begin
        errors++;
        $display("FAIL dir%0d got v=%b s=%h co=%b ov=%b want v=1 s=%h co=%b ov=%b",
                 n, out_valid8, s8, co8, ov8, t[9:2], t[1], t[0]);
      end
    end
    @(negedge CLK);
    a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [33:0] q[$];
    logic [33:0] e;
    int sent = 0, got = 0, first_acc = -1, last_out = -1;
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      @(negedge CLK);
      out_ready8 = 1'b1;
      if (sent < 16) begin
        in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'b0;
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      if (out_valid8) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_spurious cycle %0d s=%h", cyc, s8);
        end else begin
          e = q.pop_front();
          if ({ov8, co8, s8} !== {e[33], e[32], e[7:0]}) begin
            errors++;
            $display("FAIL stream_data item %0d got s=%h co=%b ov=%b want s=%h co=%b ov=%b",
                     got, s8, co8, ov8, e[7:0], e[32], e[33]);
          end
        end
        checks++;
        if (got == 0 && cyc - first_acc != 2) begin
          errors++; $display("FAIL stream_latency got %0d want 2", cyc - first_acc);
        end else if (got != 0 && cyc != last_out + 1) begin
          errors++; $display("FAIL stream_gap item %0d at cycle %0d want %0d", got, cyc, last_out + 1);
        end
        last_out = cyc;
        got++;
      end
      if (in_valid8 && in_ready8) begin
        q.push_back(model(8, 32'(a8), 32'(b8), ci8, sub8));
        if (sent == 0) first_acc = cyc;
        sent++;
      end
    end
    checks++;
    if (got != 16) begin
      errors++; $display("FAIL stream_count got %0d want 16", got);
    end
    in_valid8 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [33:0] q[$];
    logic [33:0] e;
    logic [10:0] prev;
    logic prev_stalled = 1'b0, need_new = 1'b1;
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge CLK);
      out_ready8 = !(cyc >= 2 && cyc < 7);
      if (sent < 3) begin
        if (need_new) begin
          a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'($urandom);
          need_new = 1'b0;
        end
        in_valid8 = 1'b1;
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      if (prev_stalled) begin
        checks++;
        if ({out_valid8, s8, co8, ov8} !== prev) begin
          errors++; $display("FAIL bp_hold cycle %0d got %h want %h", cyc, {out_valid8, s8, co8, ov8}, prev);
        end
      end
      if (out_valid8) begin
        checks++;
        if (in_ready8 !== out_ready8) begin
          errors++; $display("FAIL bp_ready cycle %0d got %b want %b", cyc, in_ready8, out_ready8);
        end
      end
      if (out_valid8 && out_ready8) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_dup cycle %0d s=%h", cyc, s8);
        end else begin
          e = q.pop_front();
          if ({ov8, co8, s8} !== {e[33], e[32], e[7:0]}) begin
            errors++;
            $display("FAIL bp_data item %0d got s=%h co=%b ov=%b want s=%h co=%b ov=%b",
                     got, s8, co8, ov8, e[7:0], e[32], e[33]);
          end
        end
        got++;
      end
      if (in_valid8 && in_ready8) begin
        q.push_back(model(8, 32'(a8), 32'(b8), ci8, sub8));
        sent++;
        need_new = 1'b1;
      end
      prev_stalled = out_valid8 && !out_ready8;
      prev = {out_valid8, s8, co8, ov8};
    end
    checks++;
    if (got != 3 || q.size() != 0) begin
      errors++; $display("FAIL bp_count got %0d left %0d want 3 and 0", got, q.size());
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [33:0] e;
    @(negedge CLK);
    out_ready7 = 1'b1;
    in_valid7 = 1'b1; a7 = 7'($urandom); b7 = 7'($urandom); ci7 = 1'b1; sub7 = 1'b0;
    @(posedge CLK); @(negedge CLK);
    a7 = 7'($urandom); b7 = 7'($urandom); sub7 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    in_valid7 = 1'b0; rst = 1'b1;
    @(posedge CLK); @(negedge CLK);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid7, s7, co7, ov7} !== 10'd0) begin
      errors++; $display("FAIL rstmid_clear got v=%b s=%h co=%b ov=%b want all 0", out_valid7, s7, co7, ov7);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); @(negedge CLK); #1;
      checks++;
      if (out_valid7 !== 1'b0) begin
        errors++; $display("FAIL rstmid_ghost cycle %0d got valid=%b want 0", i, out_valid7);
      end
    end
    @(negedge CLK);
    in_valid7 = 1'b1; a7 = 7'($urandom); b7 = 7'($urandom); ci7 = 1'($urandom); sub7 = 1'($urandom);
    e = model(7, 32'(a7), 32'(b7), ci7, sub7);
    @(posedge CLK); @(negedge CLK);
    in_valid7 = 1'b0;
    for (int edges = 1; edges <= 3; edges++) begin
      #1;
      checks++;
      if (out_valid7 !== (edges == 3)) begin
        errors++; $display("FAIL rstmid_latency after %0d edges got valid=%b want %b", edges, out_valid7, edges == 3);
      end
      if (edges < 3) begin
        @(posedge CLK); @(negedge CLK);
      end
    end
    checks++;
    if ({ov7, co7, s7} !== {e[33], e[32], e[6:0]}) begin
      errors++; $display("FAIL rstmid_data got s=%h co=%b ov=%b want s=%h co=%b ov=%b", s7, co7, ov7, e[6:0], e[32], e[33]);
    end
  endtask

  task automatic test_odd_widths();
    @(negedge CLK);
    in_valid7 = 1'b1; a7 = 7'h7F; b7 = 7'h01; ci7 = 1'b1; sub7 = 1'b0;
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; sub1 = 1'b0;
    @(posedge CLK); @(negedge CLK);
    in_valid7 = 1'b0; in_valid1 = 1'b0;
    #1;
    checks++;
    if ({out_valid1, s1, co1, ov1} !== 4'b1110) begin
      errors++; $display("FAIL w1 got v=%b s=%b co=%b ov=%b want v=1 s=1 co=1 ov=0", out_valid1, s1, co1, ov1);
    end
    checks++;
    if (out_valid7 !== 1'b0) begin
      errors++; $display("FAIL w7_early1 got valid=%b want 0", out_valid7);
    end
    @(posedge CLK); @(negedge CLK); #1;
    checks++;
    if (out_valid7 !== 1'b0) begin
      errors++; $display("FAIL w7_early2 got valid=%b want 0", out_valid7);
    end
    @(posedge CLK); @(negedge CLK); #1;
    checks++;
    if ({out_valid7, s7, co7, ov7} !== {1'b1, 7'h01, 1'b1, 1'b0}) begin
      errors++; $display("FAIL w7 got v=%b s=%h co=%b ov=%b want v=1 s=01 co=1 ov=0", out_valid7, s7, co7, ov7);
    end
  endtask

  task automatic test_random();
    logic [33:0] q7[$];
    logic [33:0] q1[$];
    logic [33:0] e;
    logic new7 = 1'b1, new1 = 1'b1;
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(negedge CLK);
      out_ready7 = (cyc >= 300) || ($urandom_range(0, 9) < 7);
      out_ready1 = (cyc >= 300) || ($urandom_range(0, 9) < 6);
      if (new7) begin
        a7 = 7'($urandom); b7 = 7'($urandom); ci7 = 1'($urandom); sub7 = 1'($urandom);
        in_valid7 = (cyc < 300) && ($urandom_range(0, 9) < 7);
      end
      if (new1) begin
        a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom); sub1 = 1'($urandom);
        in_valid1 = (cyc < 300) && ($urandom_range(0, 9) < 7);
      end
      #1;
      if (out_valid7 && out_ready7) begin
        checks++;
        if (q7.size() == 0) begin
          errors++; $display("FAIL rnd7_spurious cycle %0d", cyc);
        end else begin
          e = q7.pop_front();
          if ({ov7, co7, s7} !== {e[33], e[32], e[6:0]}) begin
            errors++; $display("FAIL rnd7_data cycle %0d got s=%h co=%b ov=%b want s=%h co=%b ov=%b",
                               cyc, s7, co7, ov7, e[6:0], e[32], e[33]);
          end
        end
      end
      if (out_valid1 && out_ready1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL rnd1_spurious cycle %0d", cyc);
        end else begin
          e = q1.pop_front();
          if ({ov1, co1, s1} !== {e[33], e[32], e[0]}) begin
            errors++; $display("FAIL rnd1_data cycle %0d got s=%b co=%b ov=%b want s=%b co=%b ov=%b",
                               cyc, s1, co1, ov1, e[0], e[32], e[33]);
          end
        end
      end
      new7 = !in_valid7 || in_ready7;
      new1 = !in_valid1 || in_ready1;
      if (in_valid7 && in_ready7) q7.push_back(model(7, 32'(a7), 32'(b7), ci7, sub7));
      if (in_valid1 && in_ready1) q1.push_back(model(1, 32'(a1), 32'(b1), ci1, sub1));
    end
    checks++;
    if (q7.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL rnd_drain left7=%0d left1=%0d want 0", q7.size(), q1.size());
    end
    in_valid7 = 1'b0; in_valid1 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_odd_widths();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
